// File: rtl/frame_reader_pkg.sv
// Shared types and sizing helpers for the BRAM frame reader.
// FRAME_READER_PAD_EN adds a 1-pixel zero border around the output frame.
package frame_reader_pkg;

    localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
    localparam logic [1:0] ST_ISSUE_ENC = 2'd1;
    localparam logic [1:0] ST_DRAIN_ENC = 2'd2;
    localparam logic [1:0] ST_DONE_ENC  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = ST_IDLE_ENC,
        ST_ISSUE = ST_ISSUE_ENC,
        ST_DRAIN = ST_DRAIN_ENC,
        ST_DONE  = ST_DONE_ENC
    } state_t;

`ifdef FRAME_READER_PAD_EN
    localparam int PAD = 1;
`else
    localparam int PAD = 0;
`endif

    localparam int LAST_COL_W   = 1;
    localparam int LAST_FRAME_W = 1;

    // Output frame dimension (OUT_W / OUT_H) for a given image dimension.
    function automatic int out_dim(input int img_dim);
        return img_dim + 2 * PAD;
    endfunction

    // FIFO entry is {data, row, col, last_col, last_frame}.
    function automatic int entry_width(input int data_w, input int cnt_w);
        return data_w + 2 * cnt_w + LAST_COL_W + LAST_FRAME_W;
    endfunction

endpackage

// File: rtl/frame_reader_fifo.sv
// Two-entry first-word-fall-through FIFO with occupancy count.
module frame_reader_fifo #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic [1:0]   count,
    output logic         valid
);

    logic       wr_ptr_reg;
    logic       rd_ptr_reg;
    logic [1:0] count_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_entry
            logic [W-1:0] data_reg;
            always_ff @(posedge clock) begin
                if (reset) begin
                    data_reg <= '0;
                end else if (push && (wr_ptr_reg == 1'(gi))) begin
                    data_reg <= push_data;
                end
            end
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (push) wr_ptr_reg <= ~wr_ptr_reg;
            if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
            // push+pop together (including on a full FIFO) leaves the count alone
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 2'd1;
                2'b01:   count_reg <= count_reg - 2'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign head  = rd_ptr_reg ? g_entry[1].data_reg : g_entry[0].data_reg;
    assign count = count_reg;
    assign valid = (count_reg != 2'd0);

endmodule

// File: rtl/bram_frame_reader.sv
// Raster-order frame reader for a negedge-registered single-port BRAM, streaming tagged pixels.
// Define FRAME_READER_PAD_EN to emit a 1-pixel zero border around the frame.
module bram_frame_reader
    import frame_reader_pkg::*;
#(
    parameter int RAM_WIDTH     = 8,
    parameter int RAM_ADDR_BITS = 16,
    parameter int IMG_W         = 220,
    parameter int IMG_H         = 220,
    parameter int CNT_BITS      = 9
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic [RAM_ADDR_BITS-1:0] base_addr,
    output logic                     busy,
    output logic                     done,
    output logic                     ram_enable,
    output logic                     write_enable,
    output logic [RAM_ADDR_BITS-1:0] address,
    output logic [RAM_WIDTH-1:0]     input_data,
    input  logic [RAM_WIDTH-1:0]     ram_rdata,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [RAM_WIDTH-1:0]     m_data,
    output logic [CNT_BITS-1:0]      m_row,
    output logic [CNT_BITS-1:0]      m_col,
    output logic                     m_last_col,
    output logic                     m_last_frame
);

    localparam int OUT_W = out_dim(IMG_W);
    localparam int OUT_H = out_dim(IMG_H);
    localparam int EW    = entry_width(RAM_WIDTH, CNT_BITS);
    localparam logic [CNT_BITS-1:0] LAST_COL = CNT_BITS'(OUT_W - 1);
    localparam logic [CNT_BITS-1:0] LAST_ROW = CNT_BITS'(OUT_H - 1);

    state_t                   state_reg;
    logic [RAM_ADDR_BITS-1:0] addr_reg;
    logic [CNT_BITS-1:0]      row_reg;
    logic [CNT_BITS-1:0]      col_reg;
    logic                     busy_reg;
    logic                     done_reg;
    logic                     ram_enable_reg;
    logic [RAM_ADDR_BITS-1:0] address_reg;

    logic                     inflight_reg;
    logic [CNT_BITS-1:0]      inf_row_reg;
    logic [CNT_BITS-1:0]      inf_col_reg;
    logic                     inf_last_col_reg;
    logic                     inf_last_frame_reg;
    logic                     inf_border_reg;

    logic [1:0]               fifo_count;
    logic                     fifo_valid;
    logic [EW-1:0]            fifo_head;
    logic [EW-1:0]            push_data;
    logic [RAM_WIDTH-1:0]     push_pixel;
    logic                     pop;
    logic                     cur_last_col;
    logic                     cur_last_row;
    logic                     cur_border;
    logic [2:0]               occupancy;
    logic                     can_issue;
    logic                     drain_empty;

    assign pop          = fifo_valid & m_ready;
    assign cur_last_col = (col_reg == LAST_COL);
    assign cur_last_row = (row_reg == LAST_ROW);

`ifdef FRAME_READER_PAD_EN
    assign cur_border = (row_reg == '0) || cur_last_row || (col_reg == '0) || cur_last_col;
`else
    assign cur_border = 1'b0;
`endif

    // Counting this cycle's pop keeps a full-rate stream with only two slots of storage.
    assign occupancy   = {1'b0, fifo_count} + {2'b00, inflight_reg};
    assign can_issue   = (state_reg == ST_ISSUE) && (occupancy < (3'd2 + {2'b00, pop}));
    assign drain_empty = !inflight_reg && ((fifo_count == 2'd0) || ((fifo_count == 2'd1) && pop));

    assign push_pixel = inf_border_reg ? '0 : ram_rdata;
    assign push_data  = {push_pixel, inf_row_reg, inf_col_reg, inf_last_col_reg, inf_last_frame_reg};

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg          <= ST_IDLE;
            addr_reg           <= '0;
            row_reg            <= '0;
            col_reg            <= '0;
            busy_reg           <= 1'b0;
            done_reg           <= 1'b0;
            ram_enable_reg     <= 1'b0;
            address_reg        <= '0;
            inflight_reg       <= 1'b0;
            inf_row_reg        <= '0;
            inf_col_reg        <= '0;
            inf_last_col_reg   <= 1'b0;
            inf_last_frame_reg <= 1'b0;
            inf_border_reg     <= 1'b0;
        end else begin
            ram_enable_reg <= 1'b0;
            inflight_reg   <= 1'b0;
            done_reg       <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        state_reg <= ST_ISSUE;
                        addr_reg  <= base_addr;
                        row_reg   <= '0;
                        col_reg   <= '0;
                        busy_reg  <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    if (can_issue) begin
                        // border elements take the in-flight slot without touching the BRAM
                        inflight_reg       <= 1'b1;
                        inf_row_reg        <= row_reg;
                        inf_col_reg        <= col_reg;
                        inf_last_col_reg   <= cur_last_col;
                        inf_last_frame_reg <= cur_last_col && cur_last_row;
                        inf_border_reg     <= cur_border;
                        ram_enable_reg     <= !cur_border;
                        if (!cur_border) begin
                            address_reg <= addr_reg;
                            addr_reg    <= addr_reg + 1'b1;
                        end
                        if (cur_last_col) begin
                            col_reg <= '0;
                            row_reg <= row_reg + 1'b1;
                        end else begin
                            col_reg <= col_reg + 1'b1;
                        end
                        if (cur_last_col && cur_last_row) begin
                            state_reg <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drain_empty) begin
                        state_reg <= ST_DONE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    frame_reader_fifo #(
        .W(EW)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (inflight_reg),
        .push_data (push_data),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .valid     (fifo_valid)
    );

    assign {m_data, m_row, m_col, m_last_col, m_last_frame} = fifo_head;
    assign m_valid      = fifo_valid;
    assign busy         = busy_reg;
    assign done         = done_reg;
    assign ram_enable   = ram_enable_reg;
    assign address      = address_reg;
    assign write_enable = 1'b0;
    assign input_data   = '0;

endmodule

// File: tb/tb_bram_frame_reader.sv
// Randomized bench for bram_frame_reader against a raster-order frame model and a negedge BRAM.
module tb_bram_frame_reader;
    import frame_reader_pkg::*;

    localparam int RW = 8;
    localparam int AB = 16;
    localparam int IW = 4;
    localparam int IH = 3;
    localparam int CB = 9;
    localparam int OW = out_dim(IW);
    localparam int OH = out_dim(IH);

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic [AB-1:0] base_addr;
    logic          busy, done, ram_enable, write_enable;
    logic [AB-1:0] address;
    logic [RW-1:0] input_data;
    logic [RW-1:0] ram_rdata = '0;
    logic          m_valid;
    logic          m_ready;
    logic [RW-1:0] m_data;
    logic [CB-1:0] m_row, m_col;
    logic          m_last_col, m_last_frame;

    always #5 clock = ~clock;

    bram_frame_reader #(
        .RAM_WIDTH(RW), .RAM_ADDR_BITS(AB), .IMG_W(IW), .IMG_H(IH), .CNT_BITS(CB)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .base_addr(base_addr),
        .busy(busy), .done(done), .ram_enable(ram_enable), .write_enable(write_enable),
        .address(address), .input_data(input_data), .ram_rdata(ram_rdata),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_row(m_row),
        .m_col(m_col), .m_last_col(m_last_col), .m_last_frame(m_last_frame)
    );

    function automatic logic [RW-1:0] pix(input logic [AB-1:0] a);
        return a[7:0] ^ a[15:8];
    endfunction

    // BRAM: samples enable/address on the falling edge, data is ready by the next rising edge.
    always @(negedge clock) if (ram_enable) ram_rdata <= pix(address);

    typedef struct {
        logic [RW-1:0] d;
        logic [CB-1:0] r;
        logic [CB-1:0] c;
        logic          lc;
        logic          lf;
    } px_t;

    px_t           exp_q[$];
    logic [AB-1:0] addr_q[$];
    int  vectors = 0, errors = 0;
    bit  check_on = 0, frame_active = 0, done_exp = 0;
    int  issued = 0, popped = 0, en_cycles = 0, frame_pix = 0;
    int  ready_mode = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic build_frame(input logic [AB-1:0] base);
        logic [AB-1:0] a;
        px_t e;
        bit border;
        a = base;
        for (int r = 0; r < OH; r++) begin
            for (int c = 0; c < OW; c++) begin
                border = (PAD != 0) && (r == 0 || r == OH - 1 || c == 0 || c == OW - 1);
                e.d  = border ? '0 : pix(a);
                e.r  = CB'(r);
                e.c  = CB'(c);
                e.lc = (c == OW - 1);
                e.lf = (c == OW - 1) && (r == OH - 1);
                exp_q.push_back(e);
                if (!border) begin
                    addr_q.push_back(a);
                    a = a + 1'b1;
                end
            end
        end
    endtask

    always @(negedge clock) begin
        if (check_on) begin
            check("write_enable", write_enable, 0);
            check("input_data", input_data, 0);
            check("busy", busy, frame_active);
            check("done", done, done_exp);
            done_exp = 0;
            if (ram_enable) begin
                en_cycles++;
                issued++;
                if (addr_q.size() == 0) check("unexpected read", 1, 0);
                else check("address", address, addr_q.pop_front());
            end
`ifndef FRAME_READER_PAD_EN
            check("occupancy<=2", (issued - popped) <= 2, 1);
`endif
            if (m_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected pixel", 1, 0);
                end else begin
                    check("m_data", m_data, exp_q[0].d);
                    check("m_row", m_row, exp_q[0].r);
                    check("m_col", m_col, exp_q[0].c);
                    check("m_last_col", m_last_col, exp_q[0].lc);
                    check("m_last_frame", m_last_frame, exp_q[0].lf);
                    if (m_ready) begin
                        popped++;
                        frame_pix++;
                        if (exp_q[0].lf) begin
                            frame_active = 0;
                            done_exp = 1;
                        end
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        int stall;
        stall = 0;
        m_ready = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            case (ready_mode)
                1: m_ready = ~m_ready;
                2: begin
                    if (stall > 0) begin
                        m_ready = 1'b0;
                        stall--;
                    end else begin
                        m_ready = 1'b1;
                        if ($urandom_range(0, 2) == 0) stall = $urandom_range(0, 5);
                    end
                end
                default: m_ready = 1'b1;
            endcase
        end
    end

    task automatic start_frame(input logic [AB-1:0] base, input bit check_latency);
        build_frame(base);
        en_cycles = 0;
        frame_pix = 0;
        @(posedge clock); #1;
        start = 1'b1;
        base_addr = base;
        @(posedge clock); #1;
        start = 1'b0;
        frame_active = 1;
        if (check_latency) begin
            @(negedge clock); check("m_valid after capture", m_valid, 0);
            @(negedge clock); check("m_valid after issue", m_valid, 0);
            @(negedge clock); check("m_valid after push", m_valid, 1);
`ifndef FRAME_READER_PAD_EN
            check("first pixel", m_data, 8'h10);
`endif
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (frame_active && n < 3000) begin
            @(negedge clock);
            n++;
        end
        check("frame timeout", frame_active, 0);
        repeat (3) @(negedge clock);
        check("ram_enable cycles", en_cycles, IW * IH);
        check("pixels out", frame_pix, OW * OH);
        check("leftover pixels", exp_q.size(), 0);
    endtask

    task automatic check_zero_outputs();
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst ram_enable", ram_enable, 0);
        check("rst address", address, 0);
        check("rst m_valid", m_valid, 0);
        check("rst m_data", m_data, 0);
        check("rst m_row", m_row, 0);
        check("rst m_col", m_col, 0);
        check("rst m_last_col", m_last_col, 0);
        check("rst m_last_frame", m_last_frame, 0);
    endtask

    initial begin
        int n;
        reset = 1'b1;
        start = 1'b0;
        base_addr = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_zero_outputs();
        @(posedge clock); #1;
        reset = 1'b0;
        check_on = 1;

        // model pins
        build_frame(16'h0010);
`ifndef FRAME_READER_PAD_EN
        check("model size", exp_q.size(), 12);
        check("model last data", exp_q[11].d, 8'h1B);
        check("model last_col at col3", exp_q[3].lc, 1);
        check("model row of 5th", exp_q[4].r, 1);
`else
        check("model size", exp_q.size(), OW * OH);
        check("model border zero", exp_q[0].d, 8'h00);
        check("model first interior", exp_q[OW + 1].d, 8'h10);
`endif
        exp_q.delete();
        addr_q.delete();
        build_frame(16'hFFFE);
        check("model wrap addr0", addr_q[0], 16'hFFFE);
        check("model wrap addr2", addr_q[2], 16'h0000);
        exp_q.delete();
        addr_q.delete();

        ready_mode = 0;
        start_frame(16'h0010, 1);
        wait_idle();

        ready_mode = 1;
        start_frame(16'h0010, 0);
        wait_idle();
        ready_mode = 2;
        start_frame(16'h0010, 0);
        wait_idle();

        ready_mode = 0;
        start_frame(16'hFFFE, 0);
        wait_idle();
        ready_mode = 2;
        start_frame(16'hFFFE, 0);
        wait_idle();

        // abort mid-frame with reset
        ready_mode = 0;
        start_frame(16'h0010, 0);
        n = 0;
        while (frame_pix < 4 && n < 200) begin
            @(negedge clock);
            n++;
        end
        check("reach 5th pixel", frame_pix >= 4, 1);
        @(posedge clock); #1;
        reset = 1'b1;
        check_on = 0;
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        check_zero_outputs();
        exp_q.delete();
        addr_q.delete();
        frame_active = 0;
        done_exp = 0;
        issued = 0;
        popped = 0;
        check_on = 1;
        start_frame(16'h0010, 1);
        @(posedge clock); #1;
        start = 1'b1;
        base_addr = 16'h1234;
        repeat (2) @(posedge clock);
        #1;
        start = 1'b0;
        wait_idle();

        for (int i = 0; i < 6; i++) begin
            ready_mode = $urandom_range(1, 2);
            start_frame(AB'($urandom), 0);
            wait_idle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
